// File: rtl/softmax_pkg.sv
// Shared definitions for the softmax engine and its bar feeder.
//   H          log2(rows per frame)
//   BEATS      bars per row
//   BAR_W      bar width, LANE_W-bit lanes
//   FRAME_BARS bars in one score frame
package softmax_pkg;

  localparam int H          = 5;
  localparam int BEATS      = 4;
  localparam int BAR_W      = 64;
  localparam int LANE_W     = 8;
  localparam int FRAME_BARS = (1 << H) * BEATS;

  typedef logic [BAR_W-1:0] bar_t;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    SEND  = 2'd1,
    DRAIN = 2'd2
  } feeder_state_e;

endpackage

// File: rtl/bar_frame_ram.sv
// Frame buffer for the softmax bar feeder: one write port, one registered
// read port. The read register loads zero whenever no read is requested, so
// its output doubles as the zero-when-idle bar output.
//   clk    in  clock
//   we     in  write enable
//   waddr  in  write address
//   wdata  in  write data
//   re     in  read request; rdata <= mem[raddr] if set, else 0
//   raddr  in  read address
//   rdata  out registered read data
module bar_frame_ram #(
  parameter int DEPTH = 128,
  parameter int W     = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  // NOTE: the storage array has no reset so it maps onto block RAM; only the
  // read register carries a defined value after reset (via re).
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= re ? mem[raddr] : '0;
  end

endmodule

// File: rtl/softmax_bar_feeder.sv
// Transmit side of the softmax bar interface. Buffers one full score frame
// from a valid/ready stream, replays it as a single gap-free bar_valid burst,
// then waits for the softmax output_valid to rise and fall before accepting
// the next frame.
//   clk          in  clock
//   rst          in  synchronous active-high reset
//   in_data      in  upstream bar
//   in_valid     in  upstream bar valid
//   in_ready     out feeder accepts a bar this cycle
//   bar_out      out registered bar to softmax (0 when bar_valid is 0)
//   bar_valid    out registered bar valid to softmax
//   sm_out_valid in  softmax output_valid, watched for drain
//   frame_done   out one-cycle pulse when the frame's output has drained
//   busy         out high whenever not in FILL
module softmax_bar_feeder
  import softmax_pkg::*;
#(
  parameter int H     = softmax_pkg::H,
  parameter int BEATS = softmax_pkg::BEATS,
  parameter int BAR_W = softmax_pkg::BAR_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [BAR_W-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [BAR_W-1:0] bar_out,
  output logic             bar_valid,
  input  logic             sm_out_valid,
  output logic             frame_done,
  output logic             busy
);

  localparam int N     = (1 << H) * BEATS;
  localparam int PTR_W = H + $clog2(BEATS);

  typedef logic [PTR_W-1:0] ptr_t;

  feeder_state_e state_q, state_d;
  ptr_t          wr_ptr, rd_ptr;
  logic          seen_hi;
  logic          accept, rd_en, last_wr, last_rd, drain_done;

  assign in_ready   = (state_q == FILL) & ~rst;
  assign accept     = in_valid & in_ready;
  assign rd_en      = (state_q == SEND) & ~rst;
  assign last_wr    = (wr_ptr == ptr_t'(N - 1));
  assign last_rd    = (rd_ptr == ptr_t'(N - 1));
  // Falling edge of the softmax output: it has been seen high and is now low.
  assign drain_done = (state_q == DRAIN) & seen_hi & ~sm_out_valid;
  assign frame_done = drain_done & ~rst;
  assign busy       = (state_q != FILL);

  // Read register inside the RAM is the bar_out register; it clears itself
  // whenever no read is issued, so bar_out is 0 outside the burst.
  bar_frame_ram #(
    .DEPTH (N),
    .W     (BAR_W),
    .AW    (PTR_W)
  ) u_ram (
    .clk   (clk),
    .we    (accept),
    .waddr (wr_ptr),
    .wdata (in_data),
    .re    (rd_en),
    .raddr (rd_ptr),
    .rdata (bar_out)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FILL:    if (accept && last_wr) state_d = SEND;
      SEND:    if (last_rd)           state_d = DRAIN;
      DRAIN:   if (drain_done)        state_d = FILL;
      default:                        state_d = FILL;
    endcase
  end

  // NOTE: all state here uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FILL;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      seen_hi   <= 1'b0;
      bar_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      bar_valid <= (state_q == SEND);
      // Pointers wrap by natural overflow since N is a power of two.
      if (accept)            wr_ptr <= wr_ptr + 1'b1;
      if (state_q == SEND)   rd_ptr <= rd_ptr + 1'b1;
      if (state_q == DRAIN) begin
        if (drain_done)        seen_hi <= 1'b0;
        else if (sm_out_valid) seen_hi <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_softmax_bar_feeder.sv
module tb_softmax_bar_feeder;
  import softmax_pkg::*;

  localparam int N = FRAME_BARS;

  logic clk = 1'b0;
  logic rst;
  bar_t in_data;
  logic in_valid;
  logic in_ready;
  bar_t bar_out;
  logic bar_valid;
  logic sm_out_valid;
  logic frame_done;
  logic busy;

  always #5 clk = ~clk;

  softmax_bar_feeder dut (
    .clk          (clk),
    .rst          (rst),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .bar_out      (bar_out),
    .bar_valid    (bar_valid),
    .sm_out_valid (sm_out_valid),
    .frame_done   (frame_done),
    .busy         (busy)
  );

  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Scoreboard: accepted bars are queued, replayed bars are popped in order.
  bar_t exp_q[$];
  bit   accept_next = 1'b0;
  bit   prev_valid  = 1'b0;
  int   cur_len     = 0;
  int   last_len    = 0;
  int   burst_count = 0;

  always @(negedge clk) begin
    if (bar_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL bar_unexpected: got %h expected no bar", bar_out);
      end else begin
        check("bar_data", bar_out, exp_q.pop_front());
      end
      cur_len++;
    end else begin
      if (prev_valid) begin
        last_len = cur_len;
        burst_count++;
        check("bar_out_zero_after_burst", bar_out, '0);
      end
      cur_len = 0;
    end
    prev_valid  = (bar_valid === 1'b1);
    accept_next = in_valid && in_ready && !rst;
    if (accept_next) exp_q.push_back(in_data);
  end

  task automatic push_bar(input bar_t d);
    bit ok = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    for (int t = 0; t < 1000; t++) begin
      @(posedge clk);
      if (accept_next) begin
        ok = 1'b1;
        break;
      end
    end
    #1;
    in_valid = 1'b0;
    if (!ok) begin
      checks++;
      $display("FAIL push_timeout: got no accept expected accept");
    end
  endtask

  task automatic fill_frame(input int base, input int gap);
    for (int i = 0; i < N; i++) begin
      logic [7:0] b;
      b = 8'(base + i);
      push_bar({8{b}});
      if (gap > 0 && (i % 2) == 1) repeat (gap) begin @(posedge clk); #1; end
    end
    check("in_ready_after_fill", in_ready, 1'b0);
    check("busy_after_fill", busy, 1'b1);
  endtask

  typedef struct {
    int gap;
    int sm_hi;
    bit dead;
    int base;
    int exp_len;
    int exp_q_left;
  } vec_t;

  task automatic run_frame(input vec_t v);
    int  start;
    bit  ok;
    start = burst_count;
    fill_frame(v.base, v.gap);
    if (v.dead) begin
      in_valid = 1'b1;
      in_data  = 64'hDEAD_DEAD_DEAD_DEAD;
    end
    ok = 1'b0;
    for (int t = 0; t < 3 * N; t++) begin
      @(negedge clk);
      if (burst_count > start) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      $display("FAIL burst_timeout: got no burst end expected burst end");
    end
    check("burst_len", 64'(last_len), 64'(v.exp_len));
    check("queue_left", 64'(exp_q.size()), 64'(v.exp_q_left));
    // DRAIN holds while the softmax output has not risen.
    repeat (5) begin @(posedge clk); #1; end
    check("drain_hold_done", frame_done, 1'b0);
    check("drain_hold_busy", busy, 1'b1);
    check("drain_hold_ready", in_ready, 1'b0);
    sm_out_valid = 1'b1;
    repeat (v.sm_hi) begin @(posedge clk); #1; end
    check("done_while_sm_high", frame_done, 1'b0);
    sm_out_valid = 1'b0;
    #1;
    check("frame_done_pulse", frame_done, 1'b1);
    check("ready_at_done", in_ready, 1'b0);
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("frame_done_single", frame_done, 1'b0);
    check("ready_after_done", in_ready, 1'b1);
    check("busy_after_done", busy, 1'b0);
  endtask

  vec_t vecs[4];

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{gap: 0, sm_hi: 40, dead: 1'b0, base: 0,   exp_len: N, exp_q_left: 0};
    vecs[1] = '{gap: 1, sm_hi: 40, dead: 1'b0, base: 128, exp_len: N, exp_q_left: 0};
    vecs[2] = '{gap: 0, sm_hi: 7,  dead: 1'b1, base: 37,  exp_len: N, exp_q_left: 0};
    vecs[3] = '{gap: 2, sm_hi: 1,  dead: 1'b1, base: 200, exp_len: N, exp_q_left: 0};

    rst          = 1'b1;
    in_valid     = 1'b0;
    in_data      = '0;
    sm_out_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_bar_valid", bar_valid, 1'b0);
    check("reset_bar_out", bar_out, '0);
    check("reset_frame_done", frame_done, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_in_ready_held", in_ready, 1'b0);
    rst = 1'b0;
    #1;
    check("reset_in_ready", in_ready, 1'b1);

    // Back-to-back frames: contiguity, ordering, drain handshake.
    for (int k = 0; k < 4; k++) run_frame(vecs[k]);

    // Reset in the middle of the burst discards the rest of the frame.
    fill_frame(90, 0);
    for (int t = 0; t < 3 * N; t++) begin
      @(posedge clk); #1;
      if (cur_len == 60) break;
    end
    check("reached_bar_60", 64'(cur_len), 64'd60);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("midsend_rst_bar_valid", bar_valid, 1'b0);
    check("midsend_rst_bar_out", bar_out, '0);
    check("midsend_rst_in_ready", in_ready, 1'b1);
    check("midsend_rst_busy", busy, 1'b0);
    exp_q.delete();
    @(posedge clk); #1;
    check("midsend_rst_idle", bar_valid, 1'b0);
    run_frame('{gap: 0, sm_hi: 3, dead: 1'b0, base: 1, exp_len: N, exp_q_left: 0});

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
